// File: rtl/channel_decimator.sv
// rtl/channel_decimator.sv - 2nd-order CIC decimator for the 3 MHz channel stream with output FIFO
//
// Purpose: integrates 9-bit signed channel samples on each delayed 3 MHz strobe,
// decimates by DECIM_R through a two-stage comb and queues the 16-bit result in a
// small register FIFO with a valid/ready read port and drop reporting.
//
// Ports:
//    CLK_24M             system clock, rising edge
//    reset               asynchronous active-low reset
//    enable_sampling_3M  one-cycle strobe every 8 clocks
//    channel_in[8:0]     signed channel sample, updated with the strobe
//    clear_ovf           synchronous clear of overflow and ovf_count
//    pcm_ready           downstream ready
//    pcm_valid           FIFO head valid
//    pcm_data[15:0]      FIFO head, signed, sign-extended
//    overflow            sticky: a sample was dropped
//    ovf_count[7:0]      dropped-sample count (saturating)
//
// Build option: define CHDEC_OVF_COUNT_EN to build the drop counter; without it
// ovf_count is tied to 0 and only the overflow flag reports drops.

module channel_decimator #(
   parameter int DECIM_R    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK_24M,
   input  logic        reset,
   input  logic        enable_sampling_3M,
   input  logic [8:0]  channel_in,
   input  logic        clear_ovf,
   input  logic        pcm_ready,
   output logic        pcm_valid,
   output logic [15:0] pcm_data,
   output logic        overflow,
   output logic [7:0]  ovf_count
);

   localparam int              PW           = (DECIM_R > 1) ? $clog2(DECIM_R) : 1;
   localparam int              AW           = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0]   C_LAST_PHASE = PW'(DECIM_R - 1);
   localparam logic [AW:0]     C_FULL       = (AW + 1)'(FIFO_DEPTH);

   logic          r_en_d;
   logic [PW-1:0] r_phase;
   logic [15:0]   r_i1;
   logic [15:0]   r_i2;
   logic [15:0]   r_i2_prev;
   logic [15:0]   r_c1_prev;
   logic          r_push;
   logic [15:0]   r_push_data;
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic [15:0]   w_in_ext;
   logic [15:0]   w_i1_next;
   logic [15:0]   w_i2_next;
   logic [15:0]   w_c1;
   logic [15:0]   w_comb;
   logic          w_dec;
   logic          w_full;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_drop;

   // All arithmetic is modulo 2^16; the comb output always fits, so the wrapped
   // 16-bit difference is already the sign-extended result.
   assign w_in_ext  = {{7{channel_in[8]}}, channel_in};
   assign w_i1_next = r_i1 + w_in_ext;
   assign w_i2_next = r_i2 + w_i1_next;
   assign w_c1      = w_i2_next - r_i2_prev;
   assign w_comb    = w_c1 - r_c1_prev;
   assign w_dec     = r_en_d && (r_phase == C_LAST_PHASE);

   assign w_full    = (r_count == C_FULL);
   assign w_pop     = pcm_valid && pcm_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push_ok = r_push && (!w_full || w_pop);
   assign w_drop    = r_push && w_full && !w_pop;

   assign pcm_valid = (r_count != '0);
   assign pcm_data  = r_mem[r_rd_ptr];
   assign overflow  = r_overflow;

   // CIC datapath: strobe delayed one clock so the freshly updated sample is used.
   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         r_en_d      <= 1'b0;
         r_phase     <= '0;
         r_i1        <= '0;
         r_i2        <= '0;
         r_i2_prev   <= '0;
         r_c1_prev   <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
      end else begin
         r_en_d <= enable_sampling_3M;
         r_push <= w_dec;
         if (r_en_d) begin
            r_i1    <= w_i1_next;
            r_i2    <= w_i2_next;
            r_phase <= r_phase + PW'(1);
         end
         if (w_dec) begin
            r_i2_prev   <= w_i2_next;
            r_c1_prev   <= w_c1;
            r_push_data <= w_comb;
         end
      end
   end

   // Output FIFO, contents cleared on reset so the head reads 0.
   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push_ok && !w_pop) begin
            r_count <= r_count + (AW + 1)'(1);
         end else if (w_pop && !w_push_ok) begin
            r_count <= r_count - (AW + 1)'(1);
         end
      end
   end

   // Clear has priority over a drop in the same cycle.
   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (clear_ovf) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef CHDEC_OVF_COUNT_EN
   logic [7:0] r_ovf_count;

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         r_ovf_count <= '0;
      end else if (clear_ovf) begin
         r_ovf_count <= '0;
      end else if (w_drop && (r_ovf_count != 8'hFF)) begin
         r_ovf_count <= r_ovf_count + 8'd1;
      end
   end

   assign ovf_count = r_ovf_count;
`else
   assign ovf_count = 8'd0;
`endif

endmodule
